// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM: the core data port wins
// by default, the loader/debug port is forced after MAX_WAIT denied cycles or owns the RAM during a lock.
module ram_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic {ARB = 1'b0, LOCK1 = 1'b1} state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic        r_tag0;
  logic        r_tag1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_wait_full;

  assign w_wait_full = (r_wait_cnt == WAIT_MAX);

  // Grant looks at the registered state only, so a lock taken this cycle applies from the next one.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (RESET_N) begin
      if (r_state == LOCK1)          w_gnt1 = m1_req;
      else if (m1_req && w_wait_full) w_gnt1 = 1'b1;
      else if (m0_req)               w_gnt0 = 1'b1;
      else                           w_gnt1 = m1_req;
    end
  end

  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;

  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_wren = 1'b0;
    ram_rden = 1'b0;
    if (w_gnt0) begin
      ram_addr = m0_addr;
      ram_data = m0_wdata;
      ram_wren = m0_we;
      ram_rden = ~m0_we;
    end else if (w_gnt1) begin
      ram_addr = m1_addr;
      ram_data = m1_wdata;
      ram_wren = m1_we;
      ram_rden = ~m1_we;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= ARB;
      r_wait_cnt <= '0;
      r_tag0     <= 1'b0;
      r_tag1     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values of the others.
      if (m1_req && !w_gnt1)
        r_wait_cnt <= w_wait_full ? r_wait_cnt : r_wait_cnt + 4'd1;
      else
        r_wait_cnt <= '0;

      case (r_state)
        ARB:     if (w_gnt1 && m1_lock)   r_state <= LOCK1;
        LOCK1:   if (!m1_req || !m1_lock) r_state <= ARB;
        default:                          r_state <= ARB;
      endcase

      r_tag0 <= w_gnt0 & ~m0_we;
      r_tag1 <= w_gnt1 & ~m1_we;
    end
  end

  // The RAM returns data one cycle after rden; the tag steers it to whoever issued the read.
  assign m0_rvalid = r_tag0;
  assign m1_rvalid = r_tag1;
  assign m0_rdata  = r_tag0 ? ram_q : '0;
  assign m1_rdata  = r_tag1 ? ram_q : '0;

endmodule
